imem_fetch_unit: RTL and testbench



---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_ram.sv | 23 ++
 rtl/imem_fetch_unit.sv | 103 ++++++++++
 tb/tb_imem_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch unit.
package imem_pkg;

  localparam int unsigned MAX_ADDR_W = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Full-width word index of a byte PC; callers compare the upper bits for range.
  function automatic logic [MAX_ADDR_W-1:0] word_idx(input logic [MAX_ADDR_W-1:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Word-addressed instruction RAM: one synchronous write port, one registered read port.
module imem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read samples the pre-edge contents, so a same-cycle write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// PC-driven instruction fetch with valid/ready handshake, 1-cycle latency,
// error flagging and a post-reset RAM clear sweep.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [ADDR_W-1:0]        fetch_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_W-1:0]        inst_data,
  output logic                     inst_misaligned,
  output logic                     inst_oob,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t                  state;
  logic [AW-1:0]           clr_cnt;
  logic [MAX_ADDR_W-1:0]   idx;
  logic                    pc_mis;
  logic                    pc_oob;
  logic                    accept;
  logic                    clearing;
  logic                    rd_en;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W-1:0]       ram_rdata;

  assign idx         = word_idx(MAX_ADDR_W'(fetch_pc));
  assign pc_mis      = fetch_pc[1:0] != 2'b00;
  assign pc_oob      = idx >= MAX_ADDR_W'(DEPTH);
  assign clearing    = state == CLEAR;
  assign busy        = clearing;
  assign fetch_ready = (state == READY) && (!inst_valid || inst_ready);
  assign accept      = fetch_valid && fetch_ready;
  assign rd_en       = accept && !pc_mis && !pc_oob;

  // Sweep owns the write port during CLEAR, which also masks the load port.
  assign wr_en   = !reset && (clearing || load_en);
  assign wr_addr = clearing ? clr_cnt : load_addr;
  assign wr_data = clearing ? '0 : load_data;

  // Clear-sweep state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(DEPTH - 1)) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

  // Response register: loads on accept, drains when the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_valid      <= 1'b0;
      inst_misaligned <= 1'b0;
      inst_oob        <= 1'b0;
    end else if (accept) begin
      inst_valid      <= 1'b1;
      inst_misaligned <= pc_mis;
      inst_oob        <= pc_oob;
    end else if (inst_ready) begin
      inst_valid      <= 1'b0;
    end
  end

  // RAM read register only updates on a good accept, so it holds through stalls.
  assign inst_data = (inst_valid && !inst_misaligned && !inst_oob) ? ram_rdata : '0;

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (idx[AW-1:0]),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a behavioural model.
module tb_imem_fetch_unit;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic        inst_misaligned;
  logic        inst_oob;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        busy;

  imem_fetch_unit #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_misaligned(inst_misaligned), .inst_oob(inst_oob),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [31:0] m_mem [DEPTH];
  int unsigned m_busy = 0;
  bit          m_valid = 0;
  logic [31:0] m_data = '0;
  bit          m_mis = 0;
  bit          m_oob = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs already driven; check ready, step model, compare outputs.
  task automatic cyc();
    bit          er;
    int unsigned idx;
    er = (m_busy == 0) && (!m_valid || inst_ready);
    #1;
    if (!reset) check("fetch_ready", 64'(fetch_ready), 64'(er));
    @(posedge clk);
    if (reset) begin
      m_busy  = DEPTH;
      m_valid = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else begin
      if (fetch_valid && er) begin
        idx     = fetch_pc >> 2;
        m_mis   = fetch_pc[1:0] != 2'b00;
        m_oob   = idx >= DEPTH;
        m_data  = (m_mis || m_oob) ? 32'h0 : m_mem[idx];
        m_valid = 1;
      end else if (m_valid && inst_ready) begin
        m_valid = 0;
      end
      if (load_en) m_mem[load_addr] = load_data;
    end
    #1;
    check("busy", 64'(busy), 64'(m_busy > 0));
    check("inst_valid", 64'(inst_valid), 64'(m_valid));
    if (m_valid) begin
      check("inst_data", 64'(inst_data), 64'(m_data));
      check("inst_misaligned", 64'(inst_misaligned), 64'(m_mis));
      check("inst_oob", 64'(inst_oob), 64'(m_oob));
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    cyc();
    fetch_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    cyc();
    load_en   = 1'b0;
  endtask

  initial begin
    int nb;
    foreach (m_mem[i]) m_mem[i] = '0;
    @(negedge clk);
    cyc();

    // Reset pulse and sweep length
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      reset = (i == 0);
      cyc();
      if (busy) nb++;
    end
    check("sweep_cycles", 64'(nb), 64'(32));

    // Whole RAM reads zero after the sweep
    for (int k = 0; k < 32; k++) begin
      fetch(32'(k * 4));
      check("cleared_word", 64'(inst_data), 64'(0));
    end
    cyc();

    // Load then fetch
    load(5'd3, 32'h00A00093);
    fetch(32'd12);
    check("load_fetch_valid", 64'(inst_valid), 64'(1));
    check("load_fetch_data", 64'(inst_data), 64'(32'h00A00093));
    check("load_fetch_flags", 64'({inst_misaligned, inst_oob}), 64'(0));
    cyc();

    // Back-to-back stream with a 2-cycle stall
    load(5'd0, 32'hA0);
    load(5'd1, 32'hA1);
    load(5'd2, 32'hA2);
    fetch_valid = 1'b1;
    fetch_pc = 32'd0; cyc();
    check("stream0", 64'(inst_data), 64'(32'hA0));
    fetch_pc = 32'd4; cyc();
    check("stream1", 64'(inst_data), 64'(32'hA1));
    fetch_pc = 32'd8; cyc();
    check("stream2", 64'(inst_data), 64'(32'hA2));
    fetch_pc = 32'd12; inst_ready = 1'b0;
    cyc();
    check("stall_hold_a", 64'(inst_data), 64'(32'hA2));
    check("stall_ready_a", 64'(fetch_ready), 64'(0));
    cyc();
    check("stall_hold_b", 64'(inst_data), 64'(32'hA2));
    check("stall_ready_b", 64'(fetch_ready), 64'(0));
    inst_ready = 1'b1;
    cyc();
    check("stream_resume", 64'(inst_data), 64'(32'h00A00093));
    fetch_valid = 1'b0;
    cyc();
    check("stream_drained", 64'(inst_valid), 64'(0));

    // Error responses
    fetch(32'd6);
    check("mis_flags", 64'({inst_misaligned, inst_oob}), 64'(2'b10));
    check("mis_data", 64'(inst_data), 64'(0));
    fetch(32'd128);
    check("oob_flags", 64'({inst_misaligned, inst_oob}), 64'(2'b01));
    check("oob_data", 64'(inst_data), 64'(0));
    fetch(32'd130);
    check("both_flags", 64'({inst_misaligned, inst_oob}), 64'(2'b11));
    cyc();

    // Same-cycle load/fetch hazard
    load(5'd5, 32'h11111111);
    load_en = 1'b1; load_addr = 5'd5; load_data = 32'h22222222;
    fetch(32'd20);
    load_en = 1'b0;
    check("hazard_old", 64'(inst_data), 64'(32'h11111111));
    fetch(32'd20);
    check("hazard_new", 64'(inst_data), 64'(32'h22222222));

    // Reset while a response is held, loads during the sweep
    inst_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset_drops_valid", 64'(inst_valid), 64'(0));
    check("reset_restarts_sweep", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) load(5'd5, 32'hDEADBEEF);
    inst_ready = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    fetch(32'd20);
    check("load_during_clear", 64'(inst_data), 64'(0));
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_pc    = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 159));
      inst_ready  = ($urandom_range(0, 9) < 7);
      load_en     = ($urandom_range(0, 3) == 0);
      load_addr   = 5'($urandom_range(0, 31));
      load_data   = $urandom();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
